// File: rtl/alu_divisor.sv
// Iterative unsigned restoring divider feeding the ALU result mux.
// One quotient bit per cycle; results are held until the next completed operation.
module alu_divisor #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] dividendo,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] cociente,
  output logic [n-1:0] residuo,
  output logic         busy,
  output logic         done,
  output logic         div_cero
);

  localparam int cw = $clog2(n + 1);
  localparam logic [cw-1:0] cnt_init = cw'(n);
  localparam logic [cw-1:0] cnt_last = cw'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;

  logic [cw-1:0] cnt_r;
  logic [n-1:0]  rem_r;
  logic [n-1:0]  q_r;
  logic [n-1:0]  dsr_r;
  logic [n-1:0]  cociente_r;
  logic [n-1:0]  residuo_r;
  logic          busy_r;
  logic          done_r;
  logic          div_cero_r;

  logic          accept_s;
  logic          zero_s;
  logic          last_s;
  logic          busy_nxt_s;
  logic          done_nxt_s;
  logic [n:0]    shifted_s;
  logic [n:0]    trial_s;
  logic          qbit_s;
  logic [n-1:0]  rem_nxt_s;
  logic [n-1:0]  q_nxt_s;

  assign accept_s = (state_r == IDLE) && start;
  assign zero_s   = (divisor == {n{1'b0}});
  assign last_s   = (state_r == CALC) && (cnt_r == cnt_last);

  // One restoring step: shift {R,Q}, trial-subtract, keep on no borrow.
  // trial_s[n] is a valid sign bit because the shifted remainder is always < 2*divisor.
  always_comb begin
    shifted_s = {rem_r, q_r[n-1]};
    trial_s   = shifted_s - {1'b0, dsr_r};
    qbit_s    = ~trial_s[n];
    if (qbit_s) begin
      rem_nxt_s = trial_s[n-1:0];
    end else begin
      rem_nxt_s = shifted_s[n-1:0];
    end
    q_nxt_s = {q_r[n-2:0], qbit_s};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (zero_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = CALC;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == cnt_last) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode, taken from the next state so busy/done can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      CALC:    busy_nxt_s = 1'b1;
      DONE:    done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Status flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_cero_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (accept_s) begin
        div_cero_r <= zero_s;
      end
    end
  end

  // Iteration datapath: operand capture and per-cycle restoring step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {cw{1'b0}};
      rem_r <= {n{1'b0}};
      q_r   <= {n{1'b0}};
      dsr_r <= {n{1'b0}};
    end else if (accept_s) begin
      rem_r <= {n{1'b0}};
      q_r   <= dividendo;
      dsr_r <= divisor;
      cnt_r <= zero_s ? {cw{1'b0}} : cnt_init;
    end else if (state_r == CALC) begin
      rem_r <= rem_nxt_s;
      q_r   <= q_nxt_s;
      cnt_r <= cnt_r - cnt_last;
    end
  end

  // Result registers: only written on completion, so the mux never sees partial values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cociente_r <= {n{1'b0}};
      residuo_r  <= {n{1'b0}};
    end else if (accept_s && zero_s) begin
      cociente_r <= {n{1'b1}};
      residuo_r  <= dividendo;
    end else if (last_s) begin
      cociente_r <= q_nxt_s;
      residuo_r  <= rem_nxt_s;
    end
  end

  assign cociente = cociente_r;
  assign residuo  = residuo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_cero = div_cero_r;

endmodule
